// File: rtl/adder_pkg.sv
// Shared types and configuration checks for the multicycle adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    // A legal configuration splits WIDTH into a whole number of CHUNK slices.
    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry slice; also reports the carry into its MSB.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// Adds two WIDTH-bit operands CHUNK bits per clock behind a valid/ready handshake.
// Define MULTICYCLE_ADDER_OVF_EN to add the signed-overflow output OVF.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_OUT,
`ifdef MULTICYCLE_ADDER_OVF_EN
    output logic             OVF,
`endif
    output adder_state_t     state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE, out_valid only in DONE; the result holds until taken.

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    adder_state_t     state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_chunk;
    logic [CHUNK-1:0] a_slice, b_slice, sum_c;
    logic             cout_c;

    assign last_chunk = (cnt_q == CNT_W'(N - 1));
    assign a_slice    = a_q[cnt_q*CHUNK +: CHUNK];
    assign b_slice    = b_q[cnt_q*CHUNK +: CHUNK];

`ifdef MULTICYCLE_ADDER_OVF_EN
    logic c_msb;
    logic ovf_q;
`else
    logic c_msb_unused;
`endif

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a     (a_slice),
        .b     (b_slice),
        .cin   (carry_q),
        .sum   (sum_c),
        .cout  (cout_c),
`ifdef MULTICYCLE_ADDER_OVF_EN
        .c_msb (c_msb)
`else
        .c_msb (c_msb_unused)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Operands are captured once at acceptance; input changes afterwards are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= C0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    s_q[cnt_q*CHUNK +: CHUNK] <= sum_c;
                    carry_q                   <= cout_c;
                    cnt_q                     <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_ADDER_OVF_EN
    // Only the final slice's value survives, giving carry-into-MSB XOR carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               ovf_q <= 1'b0;
        else if (state_q == RUN)  ovf_q <= c_msb ^ cout_c;
    end
    assign OVF = ovf_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign C_OUT     = carry_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: a 16/4 instance and an exhaustive 4/4 instance.
module tb_multicycle_adder;
    import adder_pkg::*;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int N  = W / C;
    localparam int W4 = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT signals ----------------
    logic          in_valid16, in_ready16, c0_16, out_valid16, out_ready16, cout16;
    logic [W-1:0]  a16, b16, s16;
    adder_state_t  state16;
`ifdef MULTICYCLE_ADDER_OVF_EN
    logic          ovf16;
`endif
    logic          in_valid4, in_ready4, c0_4, out_valid4, out_ready4, cout4;
    logic [W4-1:0] a4, b4, s4;
    adder_state_t  state4;
`ifdef MULTICYCLE_ADDER_OVF_EN
    logic          ovf4;
`endif

    multicycle_adder #(.WIDTH(W), .CHUNK(C)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .C0(c0_16), .out_valid(out_valid16), .out_ready(out_ready16),
        .S(s16), .C_OUT(cout16),
`ifdef MULTICYCLE_ADDER_OVF_EN
        .OVF(ovf16),
`endif
        .state_dbg(state16)
    );

    multicycle_adder #(.WIDTH(W4), .CHUNK(W4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(a4), .B(b4), .C0(c0_4), .out_valid(out_valid4), .out_ready(out_ready4),
        .S(s4), .C_OUT(cout4),
`ifdef MULTICYCLE_ADDER_OVF_EN
        .OVF(ovf4),
`endif
        .state_dbg(state4)
    );

    // ---------------- scoreboard ----------------
    logic [W+1:0]  exp16_q[$];   // {ovf, c_out, s}
    logic [W4+1:0] exp4_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W+1:0] model16(input logic [W-1:0] a, b, input logic c0);
        int unsigned full;
        int          sa, sb, ss;
        logic        ovf;
        full = a + b + c0;
        sa   = $signed(a);
        sb   = $signed(b);
        ss   = sa + sb + int'(c0);
        ovf  = (ss > 32767) || (ss < -32768);
        return {ovf, full >= 32'd65536, W'(full % 32'd65536)};
    endfunction

    function automatic logic [W4+1:0] model4(input logic [W4-1:0] a, b, input logic c0);
        int unsigned full;
        int          sa, sb, ss;
        logic        ovf;
        full = a + b + c0;
        sa   = $signed(a);
        sb   = $signed(b);
        ss   = sa + sb + int'(c0);
        ovf  = (ss > 7) || (ss < -8);
        return {ovf, full >= 32'd16, W4'(full % 32'd16)};
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst_n && out_valid16 && out_ready16) begin
            if (exp16_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result16: got S=0x%0h, expected no result", s16);
            end else begin
                e = exp16_q.pop_front();
                check("S16", 32'(s16), 32'(e[W-1:0]));
                check("C_OUT16", 32'(cout16), 32'(e[W]));
`ifdef MULTICYCLE_ADDER_OVF_EN
                check("OVF16", 32'(ovf16), 32'(e[W+1]));
`endif
            end
        end
    end

    always @(negedge clk) begin
        logic [W4+1:0] e;
        if (rst_n && out_valid4 && out_ready4) begin
            if (exp4_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result4: got S=0x%0h, expected no result", s4);
            end else begin
                e = exp4_q.pop_front();
                check("S4", 32'(s4), 32'(e[W4-1:0]));
                check("C_OUT4", 32'(cout4), 32'(e[W4]));
`ifdef MULTICYCLE_ADDER_OVF_EN
                check("OVF4", 32'(ovf4), 32'(e[W4+1]));
`endif
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_idle16();
        int k = 0;
        @(negedge clk);
        while (!in_ready16 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("in_ready16_wait", 32'(in_ready16), 32'd1);
    endtask

    task automatic issue16(input logic [W-1:0] a, b, input logic c0, input bit bp);
        logic [W+1:0] e;
        int lat  = 0;
        bit seen = 0;
        e = model16(a, b, c0);
        wait_idle16();
        a16 = a; b16 = b; c0_16 = c0; in_valid16 = 1'b1; out_ready16 = !bp;
        @(posedge clk); #1;
        exp16_q.push_back(e);
        in_valid16 = 1'b0;
        while (!seen && lat < 50) begin
            a16 = W'($urandom); b16 = W'($urandom); c0_16 = 1'($urandom_range(0, 1));
            in_valid16 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
            seen = out_valid16;
        end
        in_valid16 = 1'b0;
        check("latency16", 32'(lat), 32'(N));
        if (bp && seen) begin
            repeat (5) begin
                @(negedge clk);
                check("S16_hold", 32'(s16), 32'(e[W-1:0]));
                check("C_OUT16_hold", 32'(cout16), 32'(e[W]));
                check("in_ready16_done", 32'(in_ready16), 32'd0);
                check("out_valid16_hold", 32'(out_valid16), 32'd1);
            end
            @(posedge clk); #1;
            out_ready16 = 1'b1;
            @(posedge clk); #1;
            check("in_ready16_after_take", 32'(in_ready16), 32'd1);
            check("out_valid16_after_take", 32'(out_valid16), 32'd0);
            check("state16_after_take", 32'(state16), 32'(IDLE));
        end
    endtask

    task automatic issue4(input logic [W4-1:0] a, b, input logic c0);
        int lat  = 0;
        bit seen = 0;
        int k    = 0;
        @(negedge clk);
        while (!in_ready4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("in_ready4_wait", 32'(in_ready4), 32'd1);
        a4 = a; b4 = b; c0_4 = c0; in_valid4 = 1'b1; out_ready4 = 1'b1;
        @(posedge clk); #1;
        exp4_q.push_back(model4(a, b, c0));
        in_valid4 = 1'b0;
        while (!seen && lat < 20) begin
            a4 = W4'($urandom);
            @(posedge clk); #1;
            lat++;
            seen = out_valid4;
        end
        check("latency4", 32'(lat), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        in_valid16 = 0; a16 = '0; b16 = '0; c0_16 = 0; out_ready16 = 1;
        in_valid4  = 0; a4  = '0; b4  = '0; c0_4  = 0; out_ready4  = 1;
        repeat (3) @(negedge clk);
        check("reset_in_ready16", 32'(in_ready16), 32'd1);
        check("reset_out_valid16", 32'(out_valid16), 32'd0);
        check("reset_S16", 32'(s16), 32'd0);
        check("reset_C_OUT16", 32'(cout16), 32'd0);
        check("reset_state16", 32'(state16), 32'(IDLE));
        check("reset_in_ready4", 32'(in_ready4), 32'd1);
        rst_n = 1'b1;

        issue16(16'h000F, 16'h0001, 1'b0, 1'b0);
        issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue16(16'h0000, 16'h0000, 1'b1, 1'b0);
        issue16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        issue16(16'h8000, 16'h8000, 1'b0, 1'b0);
        issue16(16'h1234, 16'h4321, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++)
            issue16(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0);

        // Abort an operation two cycles into RUN; it must leave no result behind.
        wait_idle16();
        a16 = 16'h1111; b16 = 16'h2222; c0_16 = 1'b1; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid16", 32'(out_valid16), 32'd0);
        check("midrun_rst_S16", 32'(s16), 32'd0);
        check("midrun_rst_C_OUT16", 32'(cout16), 32'd0);
        check("midrun_rst_in_ready16", 32'(in_ready16), 32'd1);
        check("midrun_rst_state16", 32'(state16), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        issue16(16'hABCD, 16'h1357, 1'b1, 1'b0);
        issue16(W'($urandom), W'($urandom), 1'b0, 1'b0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c0 = 0; c0 < 2; c0++)
                    issue4(W4'(a), W4'(b), 1'(c0));

        repeat (5) @(negedge clk);
        check("exp16_q_drained", 32'(exp16_q.size()), 32'd0);
        check("exp4_q_drained", 32'(exp4_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
